tt_um_toivoh_serial_alu: RTL and testbench

Digit-serial arithmetic test harness for a TinyTapeout tile, successor to the single-cycle operand/result test block. Two operands are loaded byte-wise from `ui_in`, and an explicit start command launches a multi-cycle operation (ADD, SUB, NAND, MUL) that processes `DIGIT_BITS` per cycle. A busy flag is exported on `uio_out[7]`, and the result is read back byte-wise on `uo_out`.

---
 rtl/toivoh_salu_pkg.sv | 6 +
 rtl/toivoh_salu_step.sv | 27 ++
 rtl/tt_um_toivoh_serial_alu.sv | 117 +++++++++++
 tb/tb_tt_um_toivoh_serial_alu.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/toivoh_salu_pkg.sv
// toivoh_salu_pkg: command, op and state encodings shared by the serial ALU.
package toivoh_salu_pkg;
  typedef enum logic [1:0] {CMD_IDLE, CMD_WRITE, CMD_START, CMD_ABORT} cmd_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_NAND, OP_MUL} op_e;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/toivoh_salu_step.sv
// toivoh_salu_step: one combinational step of the digit-serial / shift-add datapath.
module toivoh_salu_step
  import toivoh_salu_pkg::*;
#(
  parameter int W = 32,
  parameter int D = 4
) (
  input  op_e          op_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         carry_i,
  input  logic [W-1:0] acc_i,
  output logic         carry_o,
  output logic [W-1:0] acc_o
);
  logic [D-1:0] yd;
  logic [D-1:0] dig;
  logic [D:0]   sum;
  // Serial ops fill the accumulator from the top so the first digit lands at bit 0.
  always_comb begin
    yd      = op_i == OP_SUB ? ~y_i[D-1:0] : y_i[D-1:0];
    sum     = {1'b0, x_i[D-1:0]} + {1'b0, yd} + {{D{1'b0}}, carry_i};
    dig     = op_i == OP_NAND ? ~(x_i[D-1:0] & y_i[D-1:0]) : sum[D-1:0];
    carry_o = sum[D];
    acc_o   = op_i == OP_MUL ? acc_i + (y_i[0] ? x_i : '0) : {dig, acc_i[W-1:D]};
  end
endmodule

// File: rtl/tt_um_toivoh_serial_alu.sv
// tt_um_toivoh_serial_alu: byte-loaded operands, multi-cycle ADD/SUB/NAND/MUL,
// busy flag on uio_out[7], byte-wise result readback on uo_out.
module tt_um_toivoh_serial_alu
  import toivoh_salu_pkg::*;
#(
  parameter int LOG2_BYTES_IN  = 3,
  parameter int LOG2_BYTES_OUT = 2,
  parameter int DIGIT_BITS     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int BI = 1 << LOG2_BYTES_IN;
  localparam int BO = 1 << LOG2_BYTES_OUT;
  localparam int W  = 4 * BI;
  localparam int D  = DIGIT_BITS;
  localparam int CW = $clog2(W) + 1;

  if (8 * BO != W) begin : g_bad_width
    $error("result width must equal operand width");
  end
  if (W % D != 0) begin : g_bad_digit
    $error("DIGIT_BITS must divide operand width");
  end

  logic [2*W-1:0] buf_q, buf_d;
  logic [W-1:0]   xs_q, xs_d, ys_q, ys_d, acc_q, acc_d, res_q, res_d, acc_s;
  logic           carry_q, carry_d, carry_s, start, last;
  logic [CW-1:0]  cnt_q, cnt_d;
  cmd_e           cmd, cmd_q;
  op_e            op_q, op_d;
  state_e         state_q, state_d;
  logic [LOG2_BYTES_IN-1:0]  sel_in;
  logic [LOG2_BYTES_OUT-1:0] sel_out;
  logic           unused_ok;

  assign cmd       = cmd_e'(uio_in[1:0]);
  assign sel_in    = uio_in[2 +: LOG2_BYTES_IN];
  assign sel_out   = uio_in[5 +: LOG2_BYTES_OUT];
  assign uo_out    = res_q[sel_out*8 +: 8];
  assign uio_out   = {state_q == RUN, 7'b0};
  assign uio_oe    = 8'h80;
  assign unused_ok = &{1'b0, ena, uio_in[7]};

  toivoh_salu_step #(.W(W), .D(D)) u_step (
    .op_i(op_q), .x_i(xs_q), .y_i(ys_q), .carry_i(carry_q), .acc_i(acc_q),
    .carry_o(carry_s), .acc_o(acc_s)
  );

  always_comb begin
    start   = cmd == CMD_START && cmd_q != CMD_START && state_q == IDLE;
    last    = cnt_q == CW'(op_q == OP_MUL ? W - 1 : W / D - 1);
    state_d = state_q;
    buf_d   = buf_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    res_d   = res_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (cmd == CMD_WRITE) buf_d[sel_in*8 +: 8] = ui_in;
      if (start) begin
        state_d = RUN;
        op_d    = op_e'(ui_in[1:0]);
        xs_d    = buf_q[W-1:0];
        ys_d    = buf_q[2*W-1:W];
        acc_d   = '0;
        carry_d = op_e'(ui_in[1:0]) == OP_SUB;
        cnt_d   = '0;
      end
    end else if (cmd == CMD_ABORT) begin
      state_d = IDLE;
    end else begin
      carry_d = carry_s;
      acc_d   = acc_s;
      xs_d    = op_q == OP_MUL ? xs_q << 1 : xs_q >> D;
      ys_d    = op_q == OP_MUL ? ys_q >> 1 : ys_q >> D;
      cnt_d   = cnt_q + 1'b1;
      state_d = last ? IDLE : RUN;
      res_d   = last ? acc_s : res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      cmd_q   <= CMD_IDLE;
      state_q <= IDLE;
    end else begin
      buf_q   <= buf_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_tt_um_toivoh_serial_alu.sv
// tb_tt_um_toivoh_serial_alu: scoreboard bench for the serial ALU tile.
module tb_tt_um_toivoh_serial_alu;
  logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0]  ui_in = '0, uo_out, uio_out, uio_oe, uio_in;
  logic [1:0]  cmd = '0, sel_out = '0;
  logic [2:0]  sel_in = '0;
  logic [31:0] mx = '0, my = '0, r, ex;
  logic [31:0] sb[$];
  int          n_cmp = 0, n_bad = 0;

  assign uio_in = {1'b0, sel_out, sel_in, cmd};
  always #5 clk = ~clk;

  tt_um_toivoh_serial_alu dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return ~(x & y);
      default: return x * y;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(output logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      sel_out = 2'(i);
      #1;
      v[i*8 +: 8] = uo_out;
    end
  endtask

  task automatic load(input logic [31:0] x, input logic [31:0] y);
    mx  = x;
    my  = y;
    cmd = 2'd1;
    for (int i = 0; i < 8; i++) begin
      sel_in = 3'(i);
      ui_in  = i < 4 ? x[i*8 +: 8] : y[(i-4)*8 +: 8];
      cyc();
    end
    cmd = 2'd0;
    cyc();
  endtask

  task automatic start(input logic [1:0] op, input bit push);
    if (push) sb.push_back(model(op, mx, my));
    cmd   = 2'd2;
    ui_in = {6'b0, op};
    cyc();
    check("busy_on", {31'b0, uio_out[7]}, 32'd1);
    cmd = 2'd0;
  endtask

  task automatic pop_cmp(input string tag);
    check({tag, "_sb_depth"}, sb.size(), 32'd1);
    if (sb.size() != 0) begin
      ex = sb.pop_front();
      rd(r);
      check({tag, "_result"}, r, ex);
    end
  endtask

  task automatic wait_done(input string tag, input int n);
    int k = 0;
    do begin
      cyc();
      k++;
    end while (uio_out[7] && k < 100);
    check({tag, "_busy_len"}, k, n);
    pop_cmp(tag);
  endtask

  initial begin
    int hi, rises;
    logic prev;
    cyc();
    cyc();
    rd(r);
    check("rst_result", r, 32'h0);
    check("rst_uio_out", {24'b0, uio_out}, 32'h0);
    check("rst_uio_oe", {24'b0, uio_oe}, 32'h80);
    rst_n = 1'b1;
    cyc();

    load(32'h0000_0001, 32'hFFFF_FFFF);
    start(2'd0, 1'b1);
    wait_done("add", 8);

    load(32'd5, 32'd7);
    start(2'd1, 1'b1);
    wait_done("sub", 8);
    sel_out = 2'd0;
    #1;
    check("sub_byte0", {24'b0, uo_out}, 32'hFE);

    load(32'h0001_0003, 32'h0000_0005);
    start(2'd3, 1'b1);
    wait_done("mul", 32);

    load(32'h0000_1234, 32'h0000_0077);
    start(2'd3, 1'b0);
    repeat (9) cyc();
    rd(r);
    check("abort_hold_prev", r, 32'h0005_000F);
    cmd = 2'd3;
    cyc();
    check("abort_busy", {31'b0, uio_out[7]}, 32'd0);
    cmd = 2'd0;
    rd(r);
    check("abort_result", r, 32'h0005_000F);
    cyc();

    load(32'hF0F0_F0F0, 32'hFF00_FF00);
    sb.push_back(model(2'd2, mx, my));
    cmd   = 2'd2;
    ui_in = 8'd2;
    hi    = 0;
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (uio_out[7]) hi++;
      if (uio_out[7] && !prev) rises++;
      prev = uio_out[7];
    end
    cmd = 2'd0;
    cyc();
    check("hold_busy_cycles", hi, 32'd8);
    check("hold_runs", rises, 32'd1);
    pop_cmp("hold");

    start(2'd2, 1'b1);
    repeat (3) cyc();
    cmd    = 2'd1;
    sel_in = 3'd4;
    ui_in  = 8'hFF;
    cyc();
    cmd = 2'd0;
    wait_done("busy_write", 4);
    start(2'd2, 1'b1);
    wait_done("b2b_nand", 8);

    load(32'h10, 32'h20);
    start(2'd0, 1'b0);
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    rd(r);
    check("midrst_result", r, 32'h0);
    check("midrst_busy", {31'b0, uio_out[7]}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    load(32'd2, 32'd3);
    start(2'd0, 1'b1);
    wait_done("add_after_rst", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
